load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus width, a multiple of 8 and at least 16.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the memory byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 256, giving the number of access cycles without ack before abort (range 1..65535).
REQ-004 The block SHALL have port clk_i, input, 1, clock; all state updates on the rising edge.
REQ-005 The block SHALL have port arst_ni, input, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port req_valid_i, input, 1, request valid from the pipeline.
REQ-007 The block SHALL have port req_ready_o, output, 1, high when the block can accept a request.
REQ-008 The block SHALL have port opcode_i, input, func_t, with LOAD = 4'b0010 and STORE = 4'b1010.
REQ-009 The block SHALL have port size_i, input, lsu_size_t (2 bits): BYTE=0, HALF=1, WORD=2 (full DATA_WIDTH), 3 reserved.
REQ-010 The block SHALL have port unsigned_i, input, 1, selecting zero-extension instead of sign-extension for loads.
REQ-011 The block SHALL have ports addr_i (input, ADDR_WIDTH, byte address) and wdata_i (input, DATA_WIDTH, store data, right-aligned).
REQ-012 The block SHALL have ports dmem_req_o, dmem_wr_o (output, 1 each) and dmem_addr_o (output, ADDR_WIDTH, lane-aligned address).
REQ-013 The block SHALL have ports dmem_be_o (output, DATA_WIDTH/8, byte enables) and dmem_wdata_o (output, DATA_WIDTH).
REQ-014 The block SHALL have ports dmem_rdata_i (input, DATA_WIDTH) and dmem_ack_i (input, 1, access complete).
REQ-015 The block SHALL have ports resp_valid_o (output, 1, one-cycle response), rd_data_o (output, DATA_WIDTH) and err_o (output, 1, error qualifier).

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready_o SHALL be high only in IDLE.
REQ-017 A request SHALL be accepted when req_valid_i and req_ready_o are both high; an opcode other than LOAD or STORE SHALL be consumed with no memory access and no response.
REQ-018 A misaligned request (HALF with addr[0]=1, WORD with any offset bit set) or size 3 SHALL go IDLE->RESP with no dmem_req_o, err_o=1 and rd_data_o=0.
REQ-019 An aligned request SHALL go IDLE->ACCESS; from the next cycle dmem_req_o=1, dmem_wr_o=1 for STORE, and dmem_addr_o = addr_i with the log2(DATA_WIDTH/8) low bits cleared.
REQ-020 dmem_be_o SHALL enable only the addressed bytes: 1 bit for BYTE, 2 for HALF, all for WORD; it SHALL be 0 outside ACCESS.
REQ-021 dmem_wdata_o SHALL replicate the byte or half across all lanes for STORE, and SHALL be 0 for LOAD and outside ACCESS.
REQ-022 In ACCESS, all dmem_* outputs SHALL stay stable until dmem_ack_i is sampled high, including an ack in the first ACCESS cycle; an ack while dmem_req_o=0 SHALL be ignored.
REQ-023 On ack the FSM SHALL go to RESP, with dmem_req_o low the following cycle.
REQ-024 For LOAD, rd_data_o SHALL be the addressed lane of dmem_rdata_i as captured at ack, sign- or zero-extended per unsigned_i; for STORE, rd_data_o SHALL be 0.
REQ-025 A counter SHALL count ACCESS cycles; if it reaches TIMEOUT without ack, the FSM SHALL go to RESP with err_o=1 and rd_data_o=0, and a late ack SHALL be ignored.
REQ-026 resp_valid_o SHALL be high for exactly one cycle, in RESP, and the FSM SHALL then return to IDLE; err_o and rd_data_o SHALL be 0 whenever resp_valid_o=0.
REQ-027 With accept at cycle N and ack at N+1, resp_valid_o SHALL be high at N+2 and req_ready_o high at N+3.
REQ-028 dmem_addr_o SHALL be 0 whenever it is not in ACCESS and SHALL never be driven to high-impedance.

Reset
REQ-029 While arst_ni=0, every output SHALL be 0, the state SHALL be IDLE and the counter 0.
REQ-030 A reset during ACCESS or RESP SHALL abort the access, produce no response, and leave the block ready for a new request after release.

Structure
REQ-031 lsu_size_t, lsu_state_t and the LOAD/STORE func_t constants SHALL live in sp_pkg.
REQ-032 Lane alignment (byte enables, write replication, read extract and extend) SHALL be a combinational sub-module lsu_lane_align.
REQ-033 A SIMULATION-only check SHALL report an error if DATA_WIDTH is not a multiple of 8 or is less than 16.

Verification (DATA_WIDTH=32, ADDR_WIDTH=32)
REQ-034 SB addr 0x103, wdata 0xA5, ack in first cycle -> dmem_addr_o 0x100, dmem_be_o 4'b1000, dmem_wdata_o 0xA5A5A5A5, dmem_wr_o 1, resp_valid_o 2 cycles after accept, err_o 0.
REQ-035 LB addr 0x102 with rdata 0x12803456 -> rd_data_o 0xFFFFFF80 with unsigned_i=0 and 0x00000080 with unsigned_i=1.
REQ-036 LH addr 0x101 -> no dmem_req_o, resp_valid_o next cycle, err_o 1, rd_data_o 0.
REQ-037 LW addr 0x200 with TIMEOUT=8 and ack withheld -> dmem_req_o high 8 cycles, then resp_valid_o with err_o 1; an ack arriving after that is ignored.
REQ-038 req_valid_i held high for two LW requests -> req_ready_o low during ACCESS/RESP and the second request accepted only after the first response.
REQ-039 arst_ni pulsed low mid-ACCESS -> all outputs 0 immediately, no resp_valid_o; the next SW to 0x4 completes normally.

Source files
------------

// File: rtl/sp_pkg.sv
// ---------------------------------------------------------------------------
// sp_pkg : shared load/store types, opcode constants and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sp_pkg;

   typedef logic [3:0] func_t;

   localparam func_t LOAD  = 4'b0010;
   localparam func_t STORE = 4'b1010;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_RSVD = 2'd3
   } lsu_size_t;

   typedef logic [1:0] lsu_state_t;

   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_ACCESS = 2'd1;
   localparam lsu_state_t ST_RESP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align : byte enables, store replication, load extract and extend
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
   import sp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NB         = DATA_WIDTH / 8,
   parameter int OFF_W      = $clog2(NB)
) (
   input  logic [OFF_W-1:0]      offset,
   input  lsu_size_t             size,
   input  logic                  unsigned_ext,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [NB-1:0]         be,
   output logic [DATA_WIDTH-1:0] wdata_rep,
   output logic [DATA_WIDTH-1:0] rdata_ext
);

   localparam logic [NB-1:0] BE_BYTE = NB'(1);
   localparam logic [NB-1:0] BE_HALF = NB'(3);

   logic [DATA_WIDTH-1:0] shifted;
   logic                  sign;

   always_comb begin
      be        = '0;
      wdata_rep = '0;
      rdata_ext = '0;
      sign      = 1'b0;
      shifted   = rdata >> {offset, 3'b000};
      case (size)
         SIZE_BYTE: begin
            be        = BE_BYTE << offset;
            wdata_rep = {NB{wdata[7:0]}};
            sign      = ~unsigned_ext & shifted[7];
            rdata_ext = {{(DATA_WIDTH-8){sign}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            be        = BE_HALF << offset;
            wdata_rep = {(NB/2){wdata[15:0]}};
            sign      = ~unsigned_ext & shifted[15];
            rdata_ext = {{(DATA_WIDTH-16){sign}}, shifted[15:0]};
         end
         SIZE_WORD: begin
            be        = '1;
            wdata_rep = wdata;
            rdata_ext = rdata;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : single-outstanding load/store sequencer with ack timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
   import sp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  func_t                   opcode_i,
   input  lsu_size_t               size_i,
   input  logic                    unsigned_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    dmem_req_o,
   output logic                    dmem_wr_o,
   output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
   output logic [DATA_WIDTH/8-1:0] dmem_be_o,
   output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
   input  logic                    dmem_ack_i,
   output logic                    resp_valid_o,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    err_o
);

   localparam int              NB       = DATA_WIDTH / 8;
   localparam int              OFF_W    = $clog2(NB);
   localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

`ifndef SYNTHESIS
   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_width
      $error("load_store_unit: DATA_WIDTH=%0d must be a multiple of 8 and >= 16", DATA_WIDTH);
   end
`endif

   lsu_state_t            state;
   logic [15:0]           cnt;
   logic                  is_store;
   lsu_size_t             req_size;
   logic                  req_unsigned;
   logic [OFF_W-1:0]      req_offset;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_err;
   logic [DATA_WIDTH-1:0] resp_data;

   logic                  in_access;
   logic                  in_resp;
   logic                  legal_op;
   logic                  misaligned;
   logic [NB-1:0]         lane_be;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [DATA_WIDTH-1:0] lane_rdata;

   assign legal_op   = (opcode_i == LOAD) || (opcode_i == STORE);
   assign misaligned = (size_i == SIZE_RSVD) ||
                       (size_i == SIZE_HALF && addr_i[0]) ||
                       (size_i == SIZE_WORD && (|addr_i[OFF_W-1:0]));

   lsu_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .offset       (req_offset),
      .size         (req_size),
      .unsigned_ext (req_unsigned),
      .wdata        (req_wdata),
      .rdata        (dmem_rdata_i),
      .be           (lane_be),
      .wdata_rep    (lane_wdata),
      .rdata_ext    (lane_rdata)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         is_store     <= 1'b0;
         req_size     <= SIZE_BYTE;
         req_unsigned <= 1'b0;
         req_offset   <= '0;
         req_addr     <= '0;
         req_wdata    <= '0;
         resp_err     <= 1'b0;
         resp_data    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Illegal opcodes are accepted and silently dropped here.
               if (req_valid_i && legal_op) begin
                  is_store     <= (opcode_i == STORE);
                  req_size     <= size_i;
                  req_unsigned <= unsigned_i;
                  req_offset   <= addr_i[OFF_W-1:0];
                  req_addr     <= {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  req_wdata    <= wdata_i;
                  cnt          <= '0;
                  resp_data    <= '0;
                  resp_err     <= misaligned;
                  state        <= misaligned ? ST_RESP : ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (dmem_ack_i) begin
                  resp_data <= is_store ? '0 : lane_rdata;
                  state     <= ST_RESP;
               end else if (cnt == TMO_LAST) begin
                  resp_err  <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_RESP: begin
               resp_err  <= 1'b0;
               resp_data <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);

   // Ready is masked by the reset input so every output reads 0 while held in reset.
   assign req_ready_o  = arst_ni && (state == ST_IDLE);
   assign dmem_req_o   = in_access;
   assign dmem_wr_o    = in_access && is_store;
   assign dmem_addr_o  = in_access ? req_addr : '0;
   assign dmem_be_o    = in_access ? lane_be : '0;
   assign dmem_wdata_o = (in_access && is_store) ? lane_wdata : '0;
   assign resp_valid_o = in_resp;
   assign err_o        = in_resp && resp_err;
   assign rd_data_o    = in_resp ? resp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
   import sp_pkg::*;

   logic        clk_i = 1'b0;
   logic        arst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   func_t       opcode_i;
   lsu_size_t   size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        dmem_req_o;
   logic        dmem_wr_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        resp_valid_o;
   logic [31:0] rd_data_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   load_store_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .TIMEOUT    (8)
   ) dut (
      .clk_i        (clk_i),
      .arst_ni      (arst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .opcode_i     (opcode_i),
      .size_i       (size_i),
      .unsigned_i   (unsigned_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_wr_o    (dmem_wr_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_ack_i   (dmem_ack_i),
      .resp_valid_o (resp_valid_o),
      .rd_data_o    (rd_data_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one request for a single edge; afterwards the DUT has taken it.
   task automatic issue(input func_t op, input lsu_size_t sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      opcode_i    = op;
      size_i      = sz;
      unsigned_i  = uns;
      addr_i      = addr;
      wdata_i     = wd;
      req_valid_i = 1'b1;
      check("ready_before_accept", 64'(req_ready_o), 64'(1));
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic ack_with(input logic [31:0] rd);
      dmem_rdata_i = rd;
      dmem_ack_i   = 1'b1;
      tick();
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      arst_ni      = 1'b0;
      req_valid_i  = 1'b0;
      opcode_i     = LOAD;
      size_i       = SIZE_BYTE;
      unsigned_i   = 1'b0;
      addr_i       = '0;
      wdata_i      = '0;
      dmem_rdata_i = '0;
      dmem_ack_i   = 1'b0;

      #1;
      check("rst_ready", 64'(req_ready_o), 64'(0));
      check("rst_dmem_req", 64'(dmem_req_o), 64'(0));
      check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      arst_ni = 1'b1;
      tick();
      check("post_rst_ready", 64'(req_ready_o), 64'(1));

      // SB 0x103 with ack in the first ACCESS cycle
      issue(STORE, SIZE_BYTE, 1'b0, 32'h103, 32'h0000_00A5);
      check("sb_req", 64'(dmem_req_o), 64'(1));
      check("sb_wr", 64'(dmem_wr_o), 64'(1));
      check("sb_addr", 64'(dmem_addr_o), 64'h100);
      check("sb_be", 64'(dmem_be_o), 64'b1000);
      check("sb_wdata", 64'(dmem_wdata_o), 64'hA5A5_A5A5);
      check("sb_ready_busy", 64'(req_ready_o), 64'(0));
      ack_with(32'h0);
      check("sb_resp_valid", 64'(resp_valid_o), 64'(1));
      check("sb_err", 64'(err_o), 64'(0));
      check("sb_rd", 64'(rd_data_o), 64'(0));
      check("sb_req_drop", 64'(dmem_req_o), 64'(0));
      tick();
      check("sb_ready_again", 64'(req_ready_o), 64'(1));
      check("sb_resp_once", 64'(resp_valid_o), 64'(0));

      // LB 0x102 signed then unsigned
      issue(LOAD, SIZE_BYTE, 1'b0, 32'h102, 32'hFFFF_FFFF);
      check("lb_be", 64'(dmem_be_o), 64'b0100);
      check("lb_wr", 64'(dmem_wr_o), 64'(0));
      check("lb_wdata", 64'(dmem_wdata_o), 64'(0));
      ack_with(32'h1280_3456);
      check("lb_signed", 64'(rd_data_o), 64'hFFFF_FF80);
      tick();
      issue(LOAD, SIZE_BYTE, 1'b1, 32'h102, 32'h0);
      ack_with(32'h1280_3456);
      check("lbu", 64'(rd_data_o), 64'h0000_0080);
      tick();

      // SH 0x102 replicates the half, LH 0x102 sign-extends the upper half
      issue(STORE, SIZE_HALF, 1'b0, 32'h102, 32'h1234_ABCD);
      check("sh_be", 64'(dmem_be_o), 64'b1100);
      check("sh_wdata", 64'(dmem_wdata_o), 64'hABCD_ABCD);
      ack_with(32'h0);
      tick();
      issue(LOAD, SIZE_HALF, 1'b0, 32'h102, 32'h0);
      ack_with(32'h8000_1234);
      check("lh_signed", 64'(rd_data_o), 64'hFFFF_8000);
      tick();

      // LW with two wait cycles: outputs hold steady until ack
      issue(LOAD, SIZE_WORD, 1'b0, 32'h204, 32'h0);
      tick();
      tick();
      check("lw_wait_req", 64'(dmem_req_o), 64'(1));
      check("lw_wait_addr", 64'(dmem_addr_o), 64'h204);
      check("lw_wait_be", 64'(dmem_be_o), 64'hF);
      ack_with(32'hCAFE_F00D);
      check("lw_rd", 64'(rd_data_o), 64'hCAFE_F00D);
      tick();

      // Ack while idle is ignored
      dmem_ack_i = 1'b1;
      tick();
      dmem_ack_i = 1'b0;
      check("idle_ack_resp", 64'(resp_valid_o), 64'(0));
      check("idle_ack_ready", 64'(req_ready_o), 64'(1));

      // Misaligned LH 0x101 and reserved size
      issue(LOAD, SIZE_HALF, 1'b0, 32'h101, 32'h0);
      check("mis_req", 64'(dmem_req_o), 64'(0));
      check("mis_resp", 64'(resp_valid_o), 64'(1));
      check("mis_err", 64'(err_o), 64'(1));
      check("mis_rd", 64'(rd_data_o), 64'(0));
      tick();
      check("mis_err_clear", 64'(err_o), 64'(0));
      issue(LOAD, SIZE_RSVD, 1'b0, 32'h100, 32'h0);
      check("rsvd_err", 64'(err_o), 64'(1));
      tick();

      // Unknown opcode: consumed, no access, no response
      issue(4'b0000, SIZE_WORD, 1'b0, 32'h100, 32'h0);
      check("badop_req", 64'(dmem_req_o), 64'(0));
      check("badop_ready", 64'(req_ready_o), 64'(1));
      tick();
      check("badop_resp", 64'(resp_valid_o), 64'(0));

      // Timeout: ack withheld on LW 0x200
      issue(LOAD, SIZE_WORD, 1'b0, 32'h200, 32'h0);
      n = 0;
      while (dmem_req_o && n < 20) begin
         n++;
         tick();
      end
      check("tmo_req_cycles", 64'(n), 64'(8));
      check("tmo_resp", 64'(resp_valid_o), 64'(1));
      check("tmo_err", 64'(err_o), 64'(1));
      check("tmo_rd", 64'(rd_data_o), 64'(0));
      dmem_ack_i = 1'b1;
      tick();
      check("late_ack_resp", 64'(resp_valid_o), 64'(0));
      tick();
      dmem_ack_i = 1'b0;
      check("late_ack_resp2", 64'(resp_valid_o), 64'(0));
      check("late_ack_req", 64'(dmem_req_o), 64'(0));

      // Back-to-back LW with req_valid held high
      opcode_i    = LOAD;
      size_i      = SIZE_WORD;
      unsigned_i  = 1'b0;
      addr_i      = 32'h300;
      req_valid_i = 1'b1;
      tick();
      check("b2b_access_ready", 64'(req_ready_o), 64'(0));
      ack_with(32'h1111_1111);
      check("b2b_resp_ready", 64'(req_ready_o), 64'(0));
      check("b2b_rd1", 64'(rd_data_o), 64'h1111_1111);
      tick();
      check("b2b_idle_ready", 64'(req_ready_o), 64'(1));
      check("b2b_idle_req", 64'(dmem_req_o), 64'(0));
      tick();
      check("b2b_second_req", 64'(dmem_req_o), 64'(1));
      req_valid_i = 1'b0;
      ack_with(32'h2222_2222);
      check("b2b_rd2", 64'(rd_data_o), 64'h2222_2222);
      tick();

      // Reset in the middle of an access
      issue(LOAD, SIZE_WORD, 1'b0, 32'h400, 32'h0);
      check("rst_mid_req", 64'(dmem_req_o), 64'(1));
      #2;
      arst_ni = 1'b0;
      #1;
      check("rst_mid_req_low", 64'(dmem_req_o), 64'(0));
      check("rst_mid_addr", 64'(dmem_addr_o), 64'(0));
      check("rst_mid_be", 64'(dmem_be_o), 64'(0));
      check("rst_mid_ready", 64'(req_ready_o), 64'(0));
      tick();
      tick();
      check("rst_mid_resp", 64'(resp_valid_o), 64'(0));
      #2;
      arst_ni = 1'b1;
      tick();
      check("rst_rel_resp", 64'(resp_valid_o), 64'(0));
      issue(STORE, SIZE_WORD, 1'b0, 32'h4, 32'hDEAD_BEEF);
      check("sw_addr", 64'(dmem_addr_o), 64'h4);
      check("sw_be", 64'(dmem_be_o), 64'hF);
      check("sw_wdata", 64'(dmem_wdata_o), 64'hDEAD_BEEF);
      ack_with(32'h0);
      check("sw_resp", 64'(resp_valid_o), 64'(1));
      check("sw_err", 64'(err_o), 64'(0));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
